ahb_slave_decoder: RTL
======================

# ahb_slave_decoder

Parametrised AHB-Lite address decoder and response multiplexer for the interconnect, sitting between one master and NUM_SLAVES slaves. It decodes the address-phase select from the top SEL_BITS of haddr. It tracks the data phase and muxes slave responses back to the master. It contains a built-in default slave that returns a two-cycle ERROR for unmapped accesses, plus fault-logging status registers.

## Interface
- ADDR_WIDTH, 32, address width
- DATA_WIDTH, 32, read data width
- NUM_SLAVES, 3, number of slaves; legal range 1 .. 2**SEL_BITS-1
- SEL_BITS, 2, number of top address bits used for region select
- hclk  in  1  clock; all state updates on rising edge
- hreset  in  1  synchronous, active-high reset
- haddr  in  ADDR_WIDTH  address-phase address
- htrans  in  2  transfer type: 0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ
- hsel  out  NUM_SLAVES  one-hot address-phase slave select
- hreadyout_s  in  NUM_SLAVES  per-slave HREADYOUT
- hresp_s  in  NUM_SLAVES  per-slave HRESP (1 = ERROR)
- hrdata_s  in  NUM_SLAVES*DATA_WIDTH  per-slave read data; slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- hready  out  1  muxed HREADY to master and all slaves
- hresp  out  1  muxed HRESP
- hrdata  out  DATA_WIDTH  muxed read data
- err_count  out  16  saturating count of ERROR responses issued by the default slave
- err_addr  out  ADDR_WIDTH  haddr of the most recent transfer that reached the default slave with NONSEQ/SEQ

## Operation
- Region decode:
  - r = haddr[ADDR_WIDTH-1 -: SEL_BITS].
  - If 1 <= r <= NUM_SLAVES: hsel[r-1] = 1.
  - Otherwise (r = 0 or r > NUM_SLAVES): hsel = 0 and the default slave is selected.
  - hsel depends on haddr only and is independent of htrans.
- Data-phase register dsel (slave index or DEFAULT):
  - Loads the address-phase decode when hready = 1.
  - Holds its value when hready = 0.
- Response mux:
  - When dsel = slave i: hready = hreadyout_s[i], hresp = hresp_s[i], hrdata = slice i of hrdata_s.
  - When dsel = DEFAULT: hready and hresp come from the default-slave FSM; hrdata = 0.
- Default-slave FSM, states IDLE, ERR1, ERR2:
  - IDLE: hready = 1, hresp = 0. Moves to ERR1 when hready = 1, the default slave is selected, and htrans[1] = 1. Otherwise stays in IDLE.
  - ERR1: hready = 0, hresp = 1. Always moves to ERR2.
  - ERR2: hready = 1, hresp = 1. Moves to ERR1 if a new NONSEQ/SEQ targets the default slave in this cycle; otherwise moves to IDLE.
  - IDLE or BUSY transfers to the default slave get a zero-wait OKAY.
- err_count increments by 1 on each entry to ERR1 and saturates at 16'hFFFF.
- err_addr loads haddr on the same cycle as the IDLE/ERR2 -> ERR1 transition.
- Reset values:
  - dsel = DEFAULT, FSM = IDLE.
  - hready = 1, hresp = 0, hrdata = 0.
  - err_count = 0, err_addr = 0.
  - hsel remains combinational from haddr.
- Reset mid-transfer: any state returns to IDLE on the next edge and the outstanding error is abandoned.

## Timing
- hsel: combinational from haddr; zero-cycle latency.
- hready, hresp, hrdata: combinational from dsel, FSM state and slave inputs. No registers in the response path.
- dsel, FSM, err_count, err_addr: registered, updated at the edge that ends the address phase (hready = 1).
- Unmapped NONSEQ accepted at edge N:
  - Cycle N+1: hready = 0, hresp = 1.
  - Cycle N+2: hready = 1, hresp = 1.
  - Total data phase is 2 cycles.
- Mapped transfer: data-phase length equals the slave's wait states plus 1. Slave wait states stall the next address phase, and hsel for that next phase stays valid throughout the stall.
- Back-to-back errors: ERR2 -> ERR1 gives a continuous ERR1/ERR2 pattern with no IDLE cycle in between.

## Test plan
- Reset: assert hreset for 2 cycles with haddr = 0x4000_0000. Required: hready = 1, hresp = 0, hrdata = 0, err_count = 0, err_addr = 0, hsel = 3'b001.
- Mapped read, NUM_SLAVES = 3, SEL_BITS = 2: NONSEQ to 0x8000_0010; slave 1 holds hreadyout_s[1] = 0 for 2 cycles, then returns 0xDEAD_BEEF. Required: hsel = 3'b010 in the address phase; hready = 0, 0, 1; hrdata = 0xDEAD_BEEF on the final cycle.
- Unmapped access: NONSEQ to 0x0000_0100. Required: hsel = 0; hready/hresp = 0/1 then 1/1; err_count = 1; err_addr = 0x0000_0100.
- Pipelined sequence: NONSEQ to slave 0 (with 1 wait state), then slave 2, then unmapped 0x0000_0000 back-to-back. Required:
  - Data phases muxed in order.
  - The slave 2 address phase is held during the slave 0 wait.
  - The ERROR pair follows slave 2's response.
  - err_count = 1.
- IDLE to unmapped, and reset during ERR1:
  - htrans = 0 to 0x0000_0000 -> zero-wait OKAY, err_count unchanged.
  - hreset asserted in ERR1 -> next cycle hready = 1, hresp = 0, err_count = 0.
- Saturation: force err_count to 16'hFFFE via 2 remaining errors after 65534 errors (or a backdoor preload), then issue 3 more unmapped NONSEQ. Required: err_count stops at 16'hFFFF and err_addr tracks the last address.

Source files
------------

// File: rtl/ahb_slave_decoder.sv
// AHB-Lite address decoder and response multiplexer with a built-in default slave
// that answers unmapped NONSEQ/SEQ transfers with a two-cycle ERROR and logs them.
module ahb_slave_decoder #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SLAVES = 3,
    parameter int SEL_BITS   = 2
) (
    input  logic                           hclk,
    input  logic                           hreset,
    input  logic [ADDR_WIDTH-1:0]          haddr,
    input  logic [1:0]                     htrans,
    output logic [NUM_SLAVES-1:0]          hsel,
    input  logic [NUM_SLAVES-1:0]          hreadyout_s,
    input  logic [NUM_SLAVES-1:0]          hresp_s,
    input  logic [NUM_SLAVES*DATA_WIDTH-1:0] hrdata_s,
    output logic                           hready,
    output logic                           hresp,
    output logic [DATA_WIDTH-1:0]          hrdata,
    output logic [15:0]                    err_count,
    output logic [ADDR_WIDTH-1:0]          err_addr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ERR1 = 2'd1,
        ERR2 = 2'd2
    } state_t;

    state_t                state_q;
    state_t                state_next;
    logic [SEL_BITS-1:0]   region;
    logic [SEL_BITS-1:0]   addr_idx;
    logic                  addr_def;
    logic [SEL_BITS-1:0]   dsel_idx;
    logic                  dsel_def;
    logic                  def_ready;
    logic                  def_resp;
    logic                  start_err;
    logic [15:0]           err_cnt_q;
    logic [ADDR_WIDTH-1:0] err_addr_q;
    logic                  unused_trans;

    // Only htrans[1] distinguishes active transfers from IDLE/BUSY.
    assign unused_trans = htrans[0];

    assign region = haddr[ADDR_WIDTH-1 -: SEL_BITS];

    always_comb begin
        hsel     = '0;
        addr_def = 1'b1;
        addr_idx = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (region == SEL_BITS'(i + 1)) begin
                hsel[i]  = 1'b1;
                addr_def = 1'b0;
                addr_idx = SEL_BITS'(i);
            end
        end
    end

    always_comb begin
        hready = def_ready;
        hresp  = def_resp;
        hrdata = '0;
        if (!dsel_def) begin
            for (int i = 0; i < NUM_SLAVES; i++) begin
                if (dsel_idx == SEL_BITS'(i)) begin
                    hready = hreadyout_s[i];
                    hresp  = hresp_s[i];
                    hrdata = hrdata_s[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
    end

    assign start_err = hready & addr_def & htrans[1];

    always_comb begin
        state_next = IDLE;
        def_ready  = 1'b1;
        def_resp   = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_err) begin
                    state_next = ERR1;
                end
            end
            ERR1: begin
                def_ready  = 1'b0;
                def_resp   = 1'b1;
                state_next = ERR2;
            end
            ERR2: begin
                def_resp = 1'b1;
                if (start_err) begin
                    state_next = ERR1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // The data-phase select only advances when the current data phase completes.
    always_ff @(posedge hclk) begin
        if (hreset) begin
            dsel_def <= 1'b1;
            dsel_idx <= '0;
        end else if (hready) begin
            dsel_def <= addr_def;
            dsel_idx <= addr_idx;
        end
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            err_cnt_q  <= '0;
            err_addr_q <= '0;
        end else if (start_err) begin
            err_addr_q <= haddr;
            if (err_cnt_q != 16'hFFFF) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign err_count = err_cnt_q;
    assign err_addr  = err_addr_q;

endmodule
